// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared grid types, sweep constants and index helpers for the rule checker.
package sudoku_pkg;
    typedef logic [3:0] cell_t;
    typedef cell_t [0:8][0:8] grid_t;

    localparam int N_UNITS = 27;
    localparam int N_CELLS = 9;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} chk_state_t;
    typedef enum logic [1:0] {U_ROW, U_COL, U_BOX} unit_t;

    function automatic logic [3:0] div3(input logic [3:0] x);
        return x >= 4'd6 ? 4'd2 : x >= 4'd3 ? 4'd1 : 4'd0;
    endfunction

    function automatic logic [3:0] mod3(input logic [3:0] x);
        return x >= 4'd6 ? x - 4'd6 : x >= 4'd3 ? x - 4'd3 : x;
    endfunction
endpackage

// File: rtl/sudoku_unit_addr.sv
// sudoku_unit_addr: maps sweep position (unit u, cell k) to grid coordinates and unit identity.
module sudoku_unit_addr
    import sudoku_pkg::*;
(
    input  logic [4:0] u,
    input  logic [3:0] k,
    output logic [3:0] r,
    output logic [3:0] c,
    output unit_t      utype,
    output logic [3:0] unum
);
    always_comb begin
        utype = u < 5'd9 ? U_ROW : u < 5'd18 ? U_COL : U_BOX;
        unum  = u < 5'd9 ? u[3:0] : u < 5'd18 ? 4'(u - 5'd9) : 4'(u - 5'd18);
        r     = utype == U_ROW ? unum : utype == U_COL ? k : 4'd3 * div3(unum) + div3(k);
        c     = utype == U_ROW ? k : utype == U_COL ? unum : 4'd3 * mod3(unum) + mod3(k);
    end
endmodule

// File: rtl/sudoku_checker.sv
// sudoku_checker: sweeps all 27 units one cell per cycle and registers per-unit conflict,
// grid-full and solved flags, held until the next sweep commits.
module sudoku_checker
    import sudoku_pkg::*;
#(
    parameter bit AUTO_RESTART = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  grid_t      grid_in,
    output logic       busy,
    output logic       done,
    output logic [8:0] row_conflict,
    output logic [8:0] col_conflict,
    output logic [8:0] box_conflict,
    output logic       grid_full,
    output logic       solved
);
    chk_state_t state_q, state_d;
    logic [4:0] u_q, u_d;
    logic [3:0] k_q, k_d;
    logic [8:0] seen_q, seen_d;
    logic [8:0] rs_q, rs_d, cs_q, cs_d, bs_q, bs_d;
    logic       sfull_q, sfull_d;
    logic [8:0] row_q, row_d, col_q, col_d, box_q, box_d;
    logic       full_q, full_d, solved_q, solved_d, done_q, done_d, busy_q, busy_d;
    logic [3:0] r, c, unum, idx;
    unit_t      utype;
    cell_t      v;
    logic       hit;

    sudoku_unit_addr u_addr (.u(u_q), .k(k_q), .r(r), .c(c), .utype(utype), .unum(unum));

    assign v   = grid_in[r][c];
    assign idx = v - 4'd1;

    always_comb begin
        state_d  = state_q;
        u_d      = u_q;
        k_d      = k_q;
        seen_d   = seen_q;
        rs_d     = rs_q;
        cs_d     = cs_q;
        bs_d     = bs_q;
        sfull_d  = sfull_q;
        row_d    = row_q;
        col_d    = col_q;
        box_d    = box_q;
        full_d   = full_q;
        solved_d = solved_q;
        done_d   = 1'b0;
        hit      = 1'b0;
        case (state_q)
            SCAN: begin
                if (v == 4'd0) begin
                    sfull_d = 1'b0;
                end else if (v <= 4'd9) begin
                    hit         = seen_q[idx];
                    seen_d[idx] = 1'b1;
                end else begin
                    hit = 1'b1;
                end
                if (hit) begin
                    if (utype == U_ROW) rs_d[unum] = 1'b1;
                    else if (utype == U_COL) cs_d[unum] = 1'b1;
                    else bs_d[unum] = 1'b1;
                end
                k_d = k_q + 4'd1;
                if (k_q == 4'(N_CELLS - 1)) begin
                    k_d    = '0;
                    seen_d = '0;
                    u_d    = u_q + 5'd1;
                    if (u_q == 5'(N_UNITS - 1)) state_d = COMMIT;
                end
            end
            COMMIT: begin
                row_d    = rs_q;
                col_d    = cs_q;
                box_d    = bs_q;
                full_d   = sfull_q;
                solved_d = sfull_q & ~|{rs_q, cs_q, bs_q};
                done_d   = 1'b1;
                state_d  = AUTO_RESTART ? SCAN : IDLE;
            end
            default: state_d = (start || AUTO_RESTART) ? SCAN : IDLE;
        endcase
        // Scratch state is re-armed every non-SCAN cycle so each sweep starts clean.
        if (state_q != SCAN) begin
            u_d     = '0;
            k_d     = '0;
            seen_d  = '0;
            rs_d    = '0;
            cs_d    = '0;
            bs_d    = '0;
            sfull_d = 1'b1;
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            u_q      <= '0;
            k_q      <= '0;
            seen_q   <= '0;
            rs_q     <= '0;
            cs_q     <= '0;
            bs_q     <= '0;
            sfull_q  <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            box_q    <= '0;
            full_q   <= 1'b0;
            solved_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            u_q      <= u_d;
            k_q      <= k_d;
            seen_q   <= seen_d;
            rs_q     <= rs_d;
            cs_q     <= cs_d;
            bs_q     <= bs_d;
            sfull_q  <= sfull_d;
            row_q    <= row_d;
            col_q    <= col_d;
            box_q    <= box_d;
            full_q   <= full_d;
            solved_q <= solved_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign row_conflict = row_q;
    assign col_conflict = col_q;
    assign box_conflict = box_q;
    assign grid_full    = full_q;
    assign solved       = solved_q;
endmodule
